// File: rtl/inert_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inert_cmd_seq_pkg
// Description : State encoding, SPI command words and a saturation helper
//               shared by the inertial command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package inert_cmd_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_PWRUP    = 3'd0;
  localparam state_t ST_INIT1    = 3'd1;
  localparam state_t ST_INIT2    = 3'd2;
  localparam state_t ST_INIT3    = 3'd3;
  localparam state_t ST_WAIT_INT = 3'd4;
  localparam state_t ST_RD_L     = 3'd5;
  localparam state_t ST_RD_H     = 3'd6;

  localparam logic [15:0] CMD_INT_CFG  = 16'h0D02;
  localparam logic [15:0] CMD_GYRO_ODR = 16'h1160;
  localparam logic [15:0] CMD_ROUND    = 16'h1440;
  localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
  localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;

  // Clamp a 17-bit signed difference into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic [16:0] val);
    if (val[16] != val[15]) return val[16] ? 16'h8000 : 16'h7FFF;
    return val[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/inert_int_sync.sv
`default_nettype none
// ============================================================================
// Module      : inert_int_sync
// Description : Two-flop synchroniser for the sensor interrupt, rising-edge
//               detector and sticky pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic int_in,
  input  logic en,
  input  logic clr,
  output logic pending
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic w_rise;

  assign w_rise = r_sync2 & ~r_sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      pending <= 1'b0;
    end else begin
      r_sync1 <= int_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // A new edge wins over a simultaneous clear so no interrupt is lost.
      if (w_rise && en)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inert_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : inert_cmd_seq
// Description : Inertial sensor SPI command sequencer: power-up delay, init
//               writes, then interrupt-driven yaw-rate reads.
//               Optional macro INERT_OFFSET_CAL_EN adds start-up offset removal.
// Revision    : 1.0 - initial release
// ============================================================================
import inert_cmd_seq_pkg::*;

module inert_cmd_seq #(
  parameter int PWRUP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        rdy
);

  state_t                  r_state;
  logic [PWRUP_BITS-1:0]   r_cnt;
  logic                    r_done;
  logic                    r_done_d;
  logic [7:0]              r_low;
  logic                    w_cmplt;
  logic                    w_pending;
  logic                    w_clr;
  logic [15:0]             w_raw;
  logic                    w_cal_done;
  logic [15:0]             w_yaw_out;
  logic                    w_unused_hi;

  assign w_unused_hi = ^rd_data[15:8];

  // Edge of the registered done, so a level left over from the last
  // transaction never counts as a new completion.
  assign w_cmplt = r_done & ~r_done_d;
  assign w_clr   = (r_state == ST_WAIT_INT) && w_pending;
  assign w_raw   = {rd_data[7:0], r_low};

  inert_int_sync u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .int_in  (INT),
    .en      (rdy),
    .clr     (w_clr),
    .pending (w_pending)
  );

`ifdef INERT_OFFSET_CAL_EN
  logic [4:0]  r_cal_cnt;
  logic [19:0] r_acc;
  logic [15:0] r_offset;
  logic [19:0] w_acc_nxt;
  logic [16:0] w_diff;
  logic        w_sample;

  assign w_sample   = (r_state == ST_RD_H) && w_cmplt;
  assign w_acc_nxt  = r_acc + {{4{w_raw[15]}}, w_raw};
  assign w_diff     = {w_raw[15], w_raw} - {r_offset[15], r_offset};
  assign w_cal_done = r_cal_cnt[4];
  assign w_yaw_out  = sat16(w_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cal_cnt <= 5'd0;
      r_acc     <= 20'd0;
      r_offset  <= 16'd0;
    end else if (w_sample && !r_cal_cnt[4]) begin
      r_acc     <= w_acc_nxt;
      r_cal_cnt <= r_cal_cnt + 5'd1;
      // Bits [19:4] are the 20-bit sum arithmetic-shifted right by 4.
      if (r_cal_cnt == 5'd15)
        r_offset <= w_acc_nxt[19:4];
    end
  end
`else
  assign w_cal_done = 1'b1;
  assign w_yaw_out  = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_PWRUP;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_done_d <= 1'b0;
      r_low    <= 8'd0;
      wrt      <= 1'b0;
      wt_data  <= 16'h0000;
      yaw_rt   <= 16'h0000;
      vld      <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      r_done   <= done;
      r_done_d <= r_done;
      wrt      <= 1'b0;
      vld      <= 1'b0;
      case (r_state)
        ST_PWRUP: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            wrt     <= 1'b1;
            wt_data <= CMD_INT_CFG;
            r_state <= ST_INIT1;
          end
        end
        ST_INIT1: if (w_cmplt) begin
          wrt     <= 1'b1;
          wt_data <= CMD_GYRO_ODR;
          r_state <= ST_INIT2;
        end
        ST_INIT2: if (w_cmplt) begin
          wrt     <= 1'b1;
          wt_data <= CMD_ROUND;
          r_state <= ST_INIT3;
        end
        ST_INIT3: if (w_cmplt) begin
          rdy     <= 1'b1;
          r_state <= ST_WAIT_INT;
        end
        ST_WAIT_INT: if (w_pending) begin
          wrt     <= 1'b1;
          wt_data <= CMD_RD_YAWL;
          r_state <= ST_RD_L;
        end
        ST_RD_L: if (w_cmplt) begin
          r_low   <= rd_data[7:0];
          wrt     <= 1'b1;
          wt_data <= CMD_RD_YAWH;
          r_state <= ST_RD_H;
        end
        ST_RD_H: if (w_cmplt) begin
          if (w_cal_done) begin
            yaw_rt <= w_yaw_out;
            vld    <= 1'b1;
          end
          r_state <= ST_WAIT_INT;
        end
        default: r_state <= ST_PWRUP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inert_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inert_cmd_seq
// Description : Scoreboard bench for inert_cmd_seq with a behavioural SPI serf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inert_cmd_seq;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_cmd[$];
  logic [15:0] exp_yaw[$];

  // serf model state
  logic        busy;
  logic [15:0] cur_cmd;
  int          stale_left;
  int          lat_left;
  int          stale_cycles = 0;
  int          serf_lat     = 4;
  logic [7:0]  serf_low     = 8'h00;
  logic [7:0]  serf_high    = 8'h00;

  inert_cmd_seq #(.PWRUP_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .wt_data (wt_data),
    .yaw_rt  (yaw_rt),
    .vld     (vld),
    .rdy     (rdy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [15:0] exp_of(input logic [15:0] raw);
`ifdef INERT_OFFSET_CAL_EN
    return raw - 16'h0010;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // SPI serf: answers each wrt after optional stale-done hold plus latency.
  initial begin
    busy = 1'b0; done = 1'b0; rd_data = 16'h0000; cur_cmd = 16'h0000;
    stale_left = 0; lat_left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0;
        done = 1'b0;
      end else if (wrt) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL wrt_overlap actual=%h required=no_wrt_while_busy", wt_data);
        end
        busy = 1'b1;
        cur_cmd = wt_data;
        stale_left = stale_cycles;
        lat_left = serf_lat;
        if (stale_left == 0) done = 1'b0;
      end else if (busy) begin
        check("wt_data_hold", wt_data, cur_cmd);
        if (stale_left > 0) begin
          stale_left--;
          if (stale_left == 0) done = 1'b0;
        end else begin
          lat_left--;
          if (lat_left <= 0) begin
            if (cur_cmd == 16'hA600)      rd_data = {8'hA5, serf_low};
            else if (cur_cmd == 16'hA700) rd_data = {8'h5A, serf_high};
            else                          rd_data = 16'hDEAD;
            done = 1'b1;
            busy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents wrt or vld.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (wrt) begin
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wrt actual=%h required=none", wt_data);
        end else begin
          check("wt_data", wt_data, exp_cmd.pop_front());
        end
      end
      if (vld) begin
        if (exp_yaw.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vld actual=%h required=none", yaw_rt);
        end else begin
          check("yaw_rt", yaw_rt, exp_yaw.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_int();
    INT = 1'b1;
    repeat (3) @(posedge clk);
    #1 INT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (exp_cmd.size() == 0 && !busy) begin ok = 1; break; end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (!ok || exp_cmd.size() != 0 || exp_yaw.size() != 0) begin
      errors++;
      $display("FAIL %s actual=cmd_left %0d yaw_left %0d required=0 0", name, exp_cmd.size(), exp_yaw.size());
    end
  endtask

  task automatic reset_and_init();
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrt", {15'd0, wrt}, 16'd0);
    check("rst_wt_data", wt_data, 16'h0000);
    check("rst_yaw_rt", yaw_rt, 16'h0000);
    check("rst_vld", {15'd0, vld}, 16'd0);
    check("rst_rdy", {15'd0, rdy}, 16'd0);
    exp_cmd.delete();
    exp_yaw.delete();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1160);
    exp_cmd.push_back(16'h1440);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (wrt) break;
    end
    check("pwrup_cycles", n[15:0], 16'd16);
    for (int i = 0; i < 400; i++) begin
      if (rdy) break;
      @(posedge clk); #1;
    end
    check("rdy_after_init", {15'd0, rdy}, 16'd1);
    check("init_cmds_left", exp_cmd.size(), 16'd0);
  endtask

  task automatic do_read(input logic [7:0] lo, input logic [7:0] hi,
                         input bit expect_vld, input logic [15:0] yaw,
                         input string name);
    serf_low = lo;
    serf_high = hi;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    if (expect_vld) exp_yaw.push_back(yaw);
    pulse_int();
    wait_idle(name);
  endtask

  initial begin
    bit seen;
    INT = 1'b0;
    rst_n = 1'b0;

    // power-up / init sequence
    reset_and_init();

`ifdef INERT_OFFSET_CAL_EN
    for (int k = 0; k < 16; k++) do_read(8'h10, 8'h00, 1'b0, 16'h0000, "cal_sample");
    do_read(8'h30, 8'h00, 1'b1, 16'h0020, "offset_read");
`endif

    // basic read
    do_read(8'h34, 8'h12, 1'b1, exp_of(16'h1234), "read_1234");
    do_read(8'hFE, 8'h80, 1'b1, exp_of(16'h80FE), "read_80fe");

    // stale done held high across each wrt
    stale_cycles = 3;
    do_read(8'hCD, 8'h7B, 1'b1, exp_of(16'h7BCD), "stale_done");
    stale_cycles = 0;

    // two INT edges during RD_L collapse into one further read pair
    serf_lat = 30;
    serf_low = 8'h78;
    serf_high = 8'h56;
    exp_cmd.push_back(16'hA600); exp_cmd.push_back(16'hA700);
    exp_cmd.push_back(16'hA600); exp_cmd.push_back(16'hA700);
    exp_yaw.push_back(exp_of(16'h5678));
    exp_yaw.push_back(exp_of(16'h5678));
    pulse_int();
    repeat (6) @(posedge clk);
    #1;
    pulse_int();
    pulse_int();
    wait_idle("collapse");

    // reset in the middle of RD_H
    serf_lat = 20;
    serf_low = 8'h11;
    serf_high = 8'h22;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    pulse_int();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (wrt && wt_data == 16'hA700) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_rd_h actual=not_seen required=A700");
    end
    repeat (5) @(posedge clk);
    #1;
    serf_lat = 4;
    reset_and_init();
    do_read(8'h01, 8'h02, 1'b1, exp_of(16'h0201), "read_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
